// File: rtl/ttt_cell_redraw_scheduler.sv
// ttt_cell_redraw_scheduler
// Sits between the 3x3 board state and the VGA adapter. Instead of redrawing
// the whole screen continuously, it keeps a shadow copy of what each cell
// currently shows on screen, marks cells whose colour changed as dirty, and
// repaints one dirty cell at a time (round-robin) at one pixel per clock.
// A full background clear runs after reset or when full_redraw is pulsed.
//
// Pixel port: x/y/color are meaningful only in a cycle where plot=1; there is
// no back-pressure, the adapter must accept one pixel per clock.
module ttt_cell_redraw_scheduler #(
  parameter int         CELL_W   = 104,
  parameter int         CELL_H   = 77,
  parameter int         PITCH_X  = 108,
  parameter int         PITCH_Y  = 81,
  parameter int         SCR_W    = 320,
  parameter int         SCR_H    = 240,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] cell_colors,
  input  logic        full_redraw,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  color,
  output logic        plot,
  output logic        busy,
  output logic [3:0]  cur_cell
);

  // Geometry constants, sized to the coordinate counters.
  localparam logic [8:0] SCR_X_LAST = 9'(SCR_W - 1);
  localparam logic [7:0] SCR_Y_LAST = 8'(SCR_H - 1);
  localparam logic [8:0] CELL_W_M1  = 9'(CELL_W - 1);
  localparam logic [7:0] CELL_H_M1  = 8'(CELL_H - 1);
  localparam logic [8:0] COL1_X     = 9'(PITCH_X);
  localparam logic [8:0] COL2_X     = 9'(2 * PITCH_X);
  localparam logic [7:0] ROW1_Y     = 8'(PITCH_Y);
  localparam logic [7:0] ROW2_Y     = 8'(2 * PITCH_Y);
  localparam logic [3:0] NO_CELL    = 4'd15;
  localparam logic [3:0] LAST_CELL  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_FILL  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Per-cell bookkeeping.
  logic [26:0] shadow;         // colour currently shown for each cell
  logic [8:0]  dirty;          // cell needs repainting
  logic [8:0]  dirty_nxt;
  logic [8:0]  mismatch;       // input colour differs from shadow
  logic        clear_pending;  // background clear requested, not yet done
  logic [3:0]  last_drawn;     // round-robin pointer
  logic [3:0]  sel;            // cell picked in IDLE, consumed in LOAD
  logic [3:0]  pick;           // round-robin winner among dirty cells
  logic        any_dirty;

  // Raster walker.
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [8:0]  x_base;         // left edge of the cell being filled
  logic [8:0]  x_end;          // right edge of the cell being filled
  logic [7:0]  y_end;          // bottom edge of the cell being filled
  logic [8:0]  step_x;
  logic [7:0]  step_y;
  logic        clear_last;
  logic        fill_last;
  logic [2:0]  fill_color;

  // Values prepared for LOAD from the selected cell index.
  logic [8:0]  load_x0;
  logic [7:0]  load_y0;
  logic [2:0]  load_color;

  assign busy      = (state != S_IDLE);
  assign any_dirty = |dirty;

  // Compare each incoming cell colour against what is on screen.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < 9; i++) begin
      mismatch[i] = (cell_colors[3*i +: 3] != shadow[3*i +: 3]);
    end
  end

  // Round-robin pick: first dirty cell at or after last_drawn+1, wrapping at 9.
  // Scanning from the far end down lets the nearest candidate win last.
  always_comb begin
    logic [3:0] start;
    logic [4:0] idx;
    pick  = '0;
    idx   = '0;
    start = (last_drawn >= LAST_CELL) ? 4'd0 : last_drawn + 4'd1;
    for (int j = 8; j >= 0; j--) begin
      idx = {1'b0, start} + 5'(j);
      if (idx >= 5'd9) idx = idx - 5'd9;
      if (dirty[idx[3:0]]) pick = idx[3:0];
    end
  end

  // Cell origin and colour for the selected cell (col = sel%3, row = sel/3).
  always_comb begin
    load_x0    = '0;
    load_y0    = '0;
    load_color = '0;
    case (sel)
      4'd1, 4'd4, 4'd7: load_x0 = COL1_X;
      4'd2, 4'd5, 4'd8: load_x0 = COL2_X;
      default:          load_x0 = '0;
    endcase
    case (sel)
      4'd3, 4'd4, 4'd5: load_y0 = ROW1_Y;
      4'd6, 4'd7, 4'd8: load_y0 = ROW2_Y;
      default:          load_y0 = '0;
    endcase
    for (int i = 0; i < 9; i++) begin
      if (sel == 4'(i)) load_color = cell_colors[3*i +: 3];
    end
  end

  // Next raster position: wrap at the screen edge in CLEAR, at the cell edge in FILL.
  always_comb begin
    step_x     = cx + 9'd1;
    step_y     = cy;
    clear_last = (cx == SCR_X_LAST) && (cy == SCR_Y_LAST);
    fill_last  = (cx == x_end) && (cy == y_end);
    if (state == S_CLEAR) begin
      if (cx == SCR_X_LAST) begin
        step_x = '0;
        step_y = cy + 8'd1;
      end
    end else if (cx == x_end) begin
      step_x = x_base;
      step_y = cy + 8'd1;
    end
  end

  // Next-state logic; clear_pending outranks dirty cells in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear_pending)  state_nxt = S_CLEAR;
        else if (any_dirty) state_nxt = S_LOAD;
      end
      S_CLEAR: if (clear_last) state_nxt = S_IDLE;
      S_LOAD:  state_nxt = S_FILL;
      S_FILL:  if (fill_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Dirty update: mismatches set bits, end of clear sets all, LOAD clears its cell last.
  always_comb begin
    dirty_nxt = dirty | mismatch;
    if (state == S_CLEAR && clear_last) dirty_nxt = '1;
    if (state == S_LOAD) begin
      for (int i = 0; i < 9; i++) begin
        if (sel == 4'(i)) dirty_nxt[i] = 1'b0;
      end
    end
  end

  // Shadow copy, dirty bits and the clear request flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow        <= '0;
      dirty         <= '0;
      clear_pending <= 1'b1;
    end else begin
      dirty <= dirty_nxt;
      if (state == S_LOAD) begin
        for (int i = 0; i < 9; i++) begin
          if (sel == 4'(i)) shadow[3*i +: 3] <= cell_colors[3*i +: 3];
        end
      end
      // Finishing a clear absorbs any request that arrived while it ran.
      if (state == S_CLEAR && clear_last) clear_pending <= 1'b0;
      else if (full_redraw)               clear_pending <= 1'b1;
    end
  end

  // Raster walker and registered pixel outputs. The edge that enters CLEAR or
  // FILL already presents the first pixel, so each state lasts exactly one
  // cycle per pixel and plot drops on the edge that returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      color      <= '0;
      plot       <= 1'b0;
      cur_cell   <= NO_CELL;
      cx         <= '0;
      cy         <= '0;
      x_base     <= '0;
      x_end      <= '0;
      y_end      <= '0;
      fill_color <= '0;
      sel        <= '0;
      last_drawn <= LAST_CELL;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          if (clear_pending) begin
            cx    <= '0;
            cy    <= '0;
            x     <= '0;
            y     <= '0;
            color <= BG_COLOR;
            plot  <= 1'b1;
          end else if (any_dirty) begin
            sel <= pick;
          end
        end
        S_CLEAR: begin
          if (clear_last) begin
            plot <= 1'b0;
          end else begin
            cx    <= step_x;
            cy    <= step_y;
            x     <= step_x;
            y     <= step_y;
            color <= BG_COLOR;
            plot  <= 1'b1;
          end
        end
        S_LOAD: begin
          cx         <= load_x0;
          cy         <= load_y0;
          x_base     <= load_x0;
          x_end      <= load_x0 + CELL_W_M1;
          y_end      <= load_y0 + CELL_H_M1;
          fill_color <= load_color;
          cur_cell   <= sel;
          last_drawn <= sel;
          x          <= load_x0;
          y          <= load_y0;
          color      <= load_color;
          plot       <= 1'b1;
        end
        S_FILL: begin
          if (fill_last) begin
            plot     <= 1'b0;
            cur_cell <= NO_CELL;
          end else begin
            cx    <= step_x;
            cy    <= step_y;
            x     <= step_x;
            y     <= step_y;
            color <= fill_color;
            plot  <= 1'b1;
          end
        end
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_cell_redraw_scheduler.sv
// Bench for ttt_cell_redraw_scheduler, run with a reduced screen/cell geometry
// so full clears and redraws stay short. Every plotted pixel is captured and
// compared against a pixel stream built from the board rules.
module tb_ttt_cell_redraw_scheduler;

  localparam int CW = 6;
  localparam int CH = 4;
  localparam int PX = 8;
  localparam int PY = 5;
  localparam int SW = 24;
  localparam int SH = 15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] cell_colors;
  logic        full_redraw;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        busy;
  logic [3:0]  cur_cell;

  always #5 clk = ~clk;

  ttt_cell_redraw_scheduler #(
    .CELL_W(CW), .CELL_H(CH), .PITCH_X(PX), .PITCH_Y(PY),
    .SCR_W(SW), .SCR_H(SH), .BG_COLOR(3'b000)
  ) dut (
    .clk(clk), .rst(rst), .cell_colors(cell_colors), .full_redraw(full_redraw),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .cur_cell(cur_cell)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Board model: what each cell should show, what is shown, round-robin pointer.
  int model_color[9];
  int model_shadow[9];
  int model_last;

  always @(negedge clk) begin
    if (plot === 1'b1) obs_q.push_back({cur_cell, color, y, x});
  end

  function automatic logic [23:0] pk(input int px, input int py, input int c, input int k);
    return {k[3:0], c[2:0], py[7:0], px[8:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_cell(input int k, input int c);
    int x0 = (k % 3) * PX;
    int y0 = (k / 3) * PY;
    for (int yy = 0; yy < CH; yy++)
      for (int xx = 0; xx < CW; xx++)
        exp_q.push_back(pk(x0 + xx, y0 + yy, c, k));
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back(pk(xx, yy, 0, 15));
  endtask

  // Cells changed together while idle are served in order starting after model_last.
  task automatic serve_dirty();
    int start = model_last;
    for (int j = 1; j <= 9; j++) begin
      int k = (start + j) % 9;
      if (model_shadow[k] != model_color[k]) begin
        push_cell(k, model_color[k]);
        model_shadow[k] = model_color[k];
        model_last = k;
      end
    end
  endtask

  // After a background clear every cell is repainted.
  task automatic serve_all();
    int start = model_last;
    for (int j = 1; j <= 9; j++) begin
      int k = (start + j) % 9;
      push_cell(k, model_color[k]);
      model_shadow[k] = model_color[k];
      model_last = k;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cell(input int k, input int c);
    cell_colors[3*k +: 3] = 3'(c);
    model_color[k] = c;
  endtask

  task automatic pulse_redraw();
    full_redraw = 1'b1;
    @(negedge clk);
    full_redraw = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int run = 0;
    for (int i = 0; i < 3000 && run < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b0) run++;
      else run = 0;
    end
    check({name, "_idle"}, 32'(run >= 4), 32'd1);
  endtask

  task automatic wait_cell(input int k);
    for (int i = 0; i < 3000 && cur_cell !== 4'(k); i++) @(negedge clk);
    check("reach_cell", 32'(cur_cell), 32'(k));
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_px%0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int k; int c;
    int fx; int fy; int lx; int ly;
  } vec_t;
  vec_t tbl[5];

  initial begin
    // Single-cell changes from idle: first and last pixel of each rectangle.
    tbl[0] = '{k: 4, c: 4, fx:  8, fy:  5, lx: 13, ly:  8};
    tbl[1] = '{k: 0, c: 7, fx:  0, fy:  0, lx:  5, ly:  3};
    tbl[2] = '{k: 8, c: 2, fx: 16, fy: 10, lx: 21, ly: 13};
    tbl[3] = '{k: 5, c: 6, fx: 16, fy:  5, lx: 21, ly:  8};
    tbl[4] = '{k: 6, c: 3, fx:  0, fy: 10, lx:  5, ly: 13};

    full_redraw = 1'b0;
    rst = 1'b0;
    cell_colors = '0;
    for (int k = 0; k < 9; k++) set_cell(k, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {7'd0, x, y, color, plot, busy, cur_cell},
          {7'd0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0, 4'd15});

    // Power-up: full clear then cells 0..8 in colour 1.
    for (int k = 0; k < 9; k++) model_shadow[k] = 0;
    model_last = 8;
    @(negedge clk);
    rst = 1'b0;
    push_clear();
    serve_all();
    wait_idle("powerup");
    check("powerup_count", 32'(obs_q.size()), 32'(SW*SH + 9*CW*CH));
    check("powerup_c4_first", 32'(obs_q[SW*SH + 4*CW*CH]), 32'(pk(8, 5, 1, 4)));
    check("powerup_c4_last", 32'(obs_q[SW*SH + 5*CW*CH - 1]), 32'(pk(13, 8, 1, 4)));
    compare_stream("powerup");

    // Table: latency and rectangle for single-cell changes.
    for (int v = 0; v < 5; v++) begin
      set_cell(tbl[v].k, tbl[v].c);
      serve_dirty();
      @(negedge clk);
      check("lat_busy_t0", 32'(busy), 32'd0);
      @(negedge clk);
      check("lat_plot_t1", 32'(plot), 32'd0);
      @(negedge clk);
      check("lat_plot_t2", 32'(plot), 32'd1);
      check("lat_cell_t2", 32'(cur_cell), 32'(tbl[v].k));
      wait_idle("tbl");
      check("tbl_count", 32'(obs_q.size()), 32'(CW*CH));
      check("tbl_first", 32'(obs_q[0]), 32'(pk(tbl[v].fx, tbl[v].fy, tbl[v].c, tbl[v].k)));
      check("tbl_last", 32'(obs_q[CW*CH - 1]), 32'(pk(tbl[v].lx, tbl[v].ly, tbl[v].c, tbl[v].k)));
      compare_stream("tbl");
    end

    // Round-robin: with last_drawn=4, cells 2 and 7 changing together -> 7 then 2.
    set_cell(4, 5);
    serve_dirty();
    wait_idle("rr_setup");
    compare_stream("rr_setup");
    set_cell(2, 3);
    set_cell(7, 6);
    serve_dirty();
    wait_idle("rr");
    check("rr_first_cell", 32'(obs_q[0][23:20]), 32'd7);
    check("rr_second_cell", 32'(obs_q[CW*CH][23:20]), 32'd2);
    compare_stream("rr");

    // Cell 0 changes during its own fill: finishes in 2, repaints in 5.
    set_cell(0, 2);
    wait_cell(0);
    repeat (4) @(negedge clk);
    set_cell(0, 5);
    push_cell(0, 2);
    push_cell(0, 5);
    model_shadow[0] = 5;
    model_last = 0;
    wait_idle("refill");
    compare_stream("refill");

    // full_redraw mid-fill of cell 3: cell 3 completes, clear, then 4..8,0..3.
    set_cell(3, (model_color[3] + 1) % 8);
    wait_cell(3);
    repeat (4) @(negedge clk);
    pulse_redraw();
    push_cell(3, model_color[3]);
    model_shadow[3] = model_color[3];
    model_last = 3;
    push_clear();
    serve_all();
    wait_idle("redraw");
    check("redraw_after_clear_cell", 32'(obs_q[CW*CH + SW*SH][23:20]), 32'd4);
    compare_stream("redraw");

    // Reset mid-fill: outputs drop without a clock edge, then full sequence.
    // A full_redraw during the following clear is absorbed.
    set_cell(5, (model_color[5] + 3) % 8);
    wait_cell(5);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {28'd0, plot, busy, 2'd0} | 32'(cur_cell), {28'd0, 4'd0} | 32'd15);
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < 9; k++) model_shadow[k] = 0;
    model_last = 8;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_clear();
    serve_all();
    repeat (20) @(negedge clk);
    pulse_redraw();
    wait_idle("rst_mid");
    compare_stream("rst_mid");

    // Randomized rounds against the board model.
    for (int r = 0; r < 12; r++) begin
      bit do_clear;
      do_clear = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 9; k++)
        if ($urandom_range(0, 2) == 0) set_cell(k, $urandom_range(0, 7));
      if (do_clear) begin
        push_clear();
        serve_all();
        pulse_redraw();
      end else begin
        serve_dirty();
      end
      wait_idle("rand");
      compare_stream("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
